ofmap_quant: RTL and testbench

OFMAP_QUANT -- requirements
Module: ofmap_quant

---
 rtl/conv_pkg.sv | 26 ++
 rtl/ofmap_quant_if.sv | 37 +++
 rtl/ofmap_quant_sat.sv | 60 ++++++
 rtl/ofmap_quant.sv | 124 ++++++++++++
 tb/tb_ofmap_quant.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// ============================================================================
// Module  : conv_pkg
// Brief   : Shared defaults and output range constants for ofmap_quant.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int OFMAP_SIZE_DFLT = 200704;
    localparam int ACC_W_DFLT      = 32;
    localparam int OUT_W_DFLT      = 16;

    localparam int OUT_MAX = 32767;
    localparam int OUT_MIN = -32768;

    typedef logic [4:0] shift_t;

    // Counter width that stays legal for a one-element frame.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ofmap_quant_if.sv
// ============================================================================
// Module  : ofmap_quant_if
// Brief   : Accumulator-in / quantized-out stream bundle for ofmap_quant.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ofmap_quant_if
    import conv_pkg::*;
#(
    parameter int ACC_W = ACC_W_DFLT,
    parameter int OUT_W = OUT_W_DFLT
);

    logic [ACC_W-1:0] ofmap_dat;
    logic             ofmap_vld;
    logic             ofmap_rdy;
    shift_t           shift;
    logic [OUT_W-1:0] qout_dat;
    logic             qout_vld;
    logic             qout_rdy;
    logic             frame_done;
    logic [15:0]      sat_cnt;

    modport master (
        output ofmap_dat, ofmap_vld, shift, qout_rdy,
        input  ofmap_rdy, qout_dat, qout_vld, frame_done, sat_cnt
    );

    modport slave (
        input  ofmap_dat, ofmap_vld, shift, qout_rdy,
        output ofmap_rdy, qout_dat, qout_vld, frame_done, sat_cnt
    );

endinterface

`default_nettype wire

// File: rtl/ofmap_quant_sat.sv
// ============================================================================
// Module  : ofmap_quant_sat
// Brief   : Combinational round-half-up, arithmetic shift and saturation.
//           Build option OFMAP_QUANT_RELU_EN clamps negative results to zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ofmap_quant_sat
    import conv_pkg::*;
#(
    parameter int ACC_W = ACC_W_DFLT,
    parameter int OUT_W = OUT_W_DFLT
) (
    input  wire logic signed [ACC_W-1:0] i_acc,
    input  wire shift_t                  i_shift,
    output logic [OUT_W-1:0]             o_q,
    output logic                         o_sat
);

    localparam logic signed [ACC_W:0] c_MAX   = (ACC_W+1)'(OUT_MAX);
    localparam logic signed [ACC_W:0] c_MIN   = (ACC_W+1)'(OUT_MIN);
    localparam logic signed [ACC_W:0] c_ONE   = (ACC_W+1)'(1);
    localparam logic [OUT_W-1:0]      c_MAX_O = OUT_W'(OUT_MAX);
    localparam logic [OUT_W-1:0]      c_MIN_O = OUT_W'(OUT_MIN);

    logic signed [ACC_W:0] w_ext;
    logic signed [ACC_W:0] w_rnd;
    logic signed [ACC_W:0] w_sum;
    logic signed [ACC_W:0] w_shr;
    logic                  w_pos;
    logic                  w_neg;
    logic [OUT_W-1:0]      w_clip;

    // One guard bit keeps the rounding add of a full-scale positive input exact.
    always_comb begin
        w_ext  = {i_acc[ACC_W-1], i_acc};
        w_rnd  = (i_shift != 5'd0) ? (c_ONE << (i_shift - 5'd1)) : '0;
        w_sum  = w_ext + w_rnd;
        w_shr  = w_sum >>> i_shift;
        w_pos  = (w_shr > c_MAX);
        w_neg  = (w_shr < c_MIN);
        w_clip = w_pos ? c_MAX_O : (w_neg ? c_MIN_O : w_shr[OUT_W-1:0]);
    end

`ifdef OFMAP_QUANT_RELU_EN
    always_comb begin
        o_q   = w_shr[ACC_W] ? '0 : w_clip;
        o_sat = w_pos;
    end
`else
    always_comb begin
        o_q   = w_clip;
        o_sat = w_pos | w_neg;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/ofmap_quant.sv
// ============================================================================
// Module  : ofmap_quant
// Brief   : Two-stage elastic pipeline quantizing conv accumulators per frame.
//           Build option OFMAP_QUANT_RELU_EN enables ReLU after saturation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ofmap_quant
    import conv_pkg::*;
#(
    parameter int OFMAP_SIZE = OFMAP_SIZE_DFLT,
    parameter int ACC_W      = ACC_W_DFLT,
    parameter int OUT_W      = OUT_W_DFLT
) (
    input  wire logic    clk,
    input  wire logic    rst,
    ofmap_quant_if.slave bus
);

    localparam int                 c_IDX_W = idx_width(OFMAP_SIZE);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(OFMAP_SIZE - 1);
    localparam logic [c_IDX_W-1:0] c_ONE   = c_IDX_W'(1);

    logic [c_IDX_W-1:0]      r_in_idx;
    logic [c_IDX_W-1:0]      r_out_idx;
    shift_t                  r_shift_q;
    logic                    r_s1_vld;
    logic signed [ACC_W-1:0] r_s1_dat;
    shift_t                  r_s1_shift;
    logic                    r_s1_first;
    logic                    r_s2_vld;
    logic [OUT_W-1:0]        r_s2_dat;
    logic [15:0]             r_sat_cnt;

    logic                    w_s2_free;
    logic                    w_s1_adv;
    logic                    w_in_rdy;
    logic                    w_in_fire;
    logic                    w_out_fire;
    logic                    w_first;
    shift_t                  w_shift_sel;
    logic [OUT_W-1:0]        w_q;
    logic                    w_sat;

    // Ready chains backwards combinationally so a full pipe still moves one per cycle.
    assign w_s2_free   = !r_s2_vld | bus.qout_rdy;
    assign w_s1_adv    = r_s1_vld & w_s2_free;
    assign w_in_rdy    = !r_s1_vld | w_s1_adv;
    assign w_in_fire   = bus.ofmap_vld & w_in_rdy & !rst;
    assign w_out_fire  = r_s2_vld & bus.qout_rdy & !rst;
    assign w_first     = (r_in_idx == '0);
    assign w_shift_sel = w_first ? bus.shift : r_shift_q;

    assign bus.ofmap_rdy  = w_in_rdy & !rst;
    assign bus.qout_vld   = r_s2_vld & !rst;
    assign bus.qout_dat   = rst ? '0 : r_s2_dat;
    assign bus.frame_done = w_out_fire & (r_out_idx == c_LAST);
    assign bus.sat_cnt    = rst ? '0 : r_sat_cnt;

    ofmap_quant_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .i_acc   (r_s1_dat),
        .i_shift (r_s1_shift),
        .o_q     (w_q),
        .o_sat   (w_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_idx   <= '0;
            r_out_idx  <= '0;
            r_shift_q  <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_dat   <= '0;
            r_s1_shift <= '0;
            r_s1_first <= 1'b0;
            r_s2_vld   <= 1'b0;
            r_s2_dat   <= '0;
            r_sat_cnt  <= '0;
        end else begin
            if (w_in_fire) begin
                r_s1_dat   <= bus.ofmap_dat;
                r_s1_shift <= w_shift_sel;
                r_s1_first <= w_first;
                r_in_idx   <= (r_in_idx == c_LAST) ? '0 : r_in_idx + c_ONE;
                if (w_first) begin
                    r_shift_q <= bus.shift;
                end
            end

            if (w_in_fire) begin
                r_s1_vld <= 1'b1;
            end else if (w_s1_adv) begin
                r_s1_vld <= 1'b0;
            end

            // The frame's first element restarts the saturation tally.
            if (w_s1_adv) begin
                r_s2_dat <= w_q;
                if (r_s1_first) begin
                    r_sat_cnt <= {15'd0, w_sat};
                end else if (w_sat && (r_sat_cnt != 16'hFFFF)) begin
                    r_sat_cnt <= r_sat_cnt + 16'd1;
                end
            end

            if (w_s1_adv) begin
                r_s2_vld <= 1'b1;
            end else if (w_out_fire) begin
                r_s2_vld <= 1'b0;
            end

            if (w_out_fire) begin
                r_out_idx <= (r_out_idx == c_LAST) ? '0 : r_out_idx + c_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ofmap_quant.sv
// ============================================================================
// Module  : tb_ofmap_quant
// Brief   : Scoreboard bench for ofmap_quant with a four-element frame.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ofmap_quant;

    localparam int c_FRAME = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ofmap_quant_if #(.ACC_W(32), .OUT_W(16)) qif ();

    ofmap_quant #(
        .OFMAP_SIZE (c_FRAME),
        .ACC_W      (32),
        .OUT_W      (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (qif.slave)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] sb[$];
    int          m_in_idx  = 0;
    int          m_out_idx = 0;
    logic [4:0]  m_shift_q = '0;
    int          n_in  = 0;
    int          n_out = 0;
    int          n_fd  = 0;
    int          cyc   = 0;
    logic [15:0] mon_exp;
    logic [4:0]  mon_sh;
    bit          mon_fire;
    bit          mon_fd;

    function automatic logic [15:0] q_model(input logic [31:0] d, input logic [4:0] s);
        longint v;
        int     sh;
        sh = int'(s);
        v  = longint'($signed(d));
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
`ifdef OFMAP_QUANT_RELU_EN
        if (v < 0) v = 0;
`endif
        return v[15:0];
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard: push on input accept, pop and compare on output transfer.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_in_idx  = 0;
            m_out_idx = 0;
            m_shift_q = '0;
        end else begin
            mon_fire = qif.qout_vld && qif.qout_rdy;
            mon_fd   = mon_fire && (m_out_idx == c_FRAME - 1);
            checks++;
            if (qif.frame_done !== mon_fd) begin
                failures++;
                $display("FAIL frame_done out_idx=%0d got=%b exp=%b", m_out_idx, qif.frame_done, mon_fd);
            end
            if (qif.frame_done === 1'b1) n_fd++;
            if (mon_fire) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL qout_extra got=%h exp=<none>", qif.qout_dat);
                end else begin
                    mon_exp = sb.pop_front();
                    if (qif.qout_dat !== mon_exp) begin
                        failures++;
                        $display("FAIL qout_dat out#%0d got=%h exp=%h", n_out, qif.qout_dat, mon_exp);
                    end
                end
                m_out_idx = (m_out_idx == c_FRAME - 1) ? 0 : m_out_idx + 1;
                n_out++;
            end
            if (qif.ofmap_vld && qif.ofmap_rdy) begin
                mon_sh = (m_in_idx == 0) ? qif.shift : m_shift_q;
                if (m_in_idx == 0) m_shift_q = qif.shift;
                sb.push_back(q_model(qif.ofmap_dat, mon_sh));
                m_in_idx = (m_in_idx == c_FRAME - 1) ? 0 : m_in_idx + 1;
                n_in++;
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic push_in(input logic [31:0] d, input logic [4:0] sh);
        int t;
        t = 0;
        qif.ofmap_vld = 1'b1;
        qif.ofmap_dat = d;
        qif.shift     = sh;
        @(negedge clk);
        while (!qif.ofmap_rdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++;
            failures++;
            $display("FAIL push_timeout got=ofmap_rdy_low exp=accept");
        end
        @(posedge clk);
        #1;
        qif.ofmap_vld = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || qif.qout_vld) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d_pending exp=0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (qif.ofmap_rdy !== 1'b0) begin failures++; $display("FAIL rst_ofmap_rdy got=%b exp=0", qif.ofmap_rdy); end
        if (qif.qout_vld !== 1'b0) begin failures++; $display("FAIL rst_qout_vld got=%b exp=0", qif.qout_vld); end
        if (qif.qout_dat !== 16'h0) begin failures++; $display("FAIL rst_qout_dat got=%h exp=0000", qif.qout_dat); end
        if (qif.frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done got=%b exp=0", qif.frame_done); end
        if (qif.sat_cnt !== 16'h0) begin failures++; $display("FAIL rst_sat_cnt got=%h exp=0000", qif.sat_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        qif.ofmap_vld = 1'b1;
        qif.ofmap_dat = 32'h0000_0128;
        qif.shift     = 5'd4;
        @(negedge clk);
        checks += 2;
        if (qif.ofmap_rdy !== 1'b1) begin failures++; $display("FAIL lat_rdy got=%b exp=1", qif.ofmap_rdy); end
        if (qif.qout_vld !== 1'b0) begin failures++; $display("FAIL lat_n0 got=%b exp=0", qif.qout_vld); end
        @(posedge clk);
        #1;
        qif.ofmap_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (qif.qout_vld !== 1'b0) begin failures++; $display("FAIL lat_n1 got=%b exp=0", qif.qout_vld); end
        @(negedge clk);
        checks += 2;
        if (qif.qout_vld !== 1'b1) begin failures++; $display("FAIL lat_n2 got=%b exp=1", qif.qout_vld); end
        if (qif.qout_dat !== 16'h0013) begin failures++; $display("FAIL round_q got=%h exp=0013", qif.qout_dat); end
        @(posedge clk);
        #1;
        repeat (3) push_in(32'h0, 5'd4);
        wait_drain();
        checks++;
        if (qif.sat_cnt !== 16'd0) begin failures++; $display("FAIL basic_sat_cnt got=%0d exp=0", qif.sat_cnt); end
    endtask

    task automatic test_saturate();
        int exp_sat;
`ifdef OFMAP_QUANT_RELU_EN
        exp_sat = 1;
`else
        exp_sat = 2;
`endif
        push_in(32'h7FFF_FFFF, 5'd0);
        push_in(32'h8000_0000, 5'd0);
        push_in(32'h0000_0005, 5'd0);
        push_in(32'hFFFF_FFFB, 5'd0);
        wait_drain();
        checks++;
        if (qif.sat_cnt !== 16'(exp_sat)) begin failures++; $display("FAIL sat_cnt got=%0d exp=%0d", qif.sat_cnt, exp_sat); end
    endtask

    task automatic test_negative();
        logic [15:0] exp_neg;
`ifdef OFMAP_QUANT_RELU_EN
        exp_neg = 16'h0000;
`else
        exp_neg = 16'hFFF0;
`endif
        push_in(32'hFFFF_FF00, 5'd4);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (qif.qout_dat !== exp_neg || qif.qout_vld !== 1'b1) begin
            failures++;
            $display("FAIL neg_q got=%h/%b exp=%h/1", qif.qout_dat, qif.qout_vld, exp_neg);
        end
        @(posedge clk);
        #1;
        push_in(32'h0000_0100, 5'd9);
        push_in(32'hFFFF_FFF8, 5'd0);
        push_in(32'h0000_0007, 5'd0);
        wait_drain();
        checks++;
        if (qif.sat_cnt !== 16'd0) begin failures++; $display("FAIL neg_sat_cnt got=%0d exp=0", qif.sat_cnt); end
    endtask

    task automatic test_stall();
        int in0, out0;
        in0  = n_in;
        out0 = n_out;
        qif.qout_rdy = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) push_in(32'(1000 * (i + 1) + 16), 5'd3);
            end
            begin
                repeat (10) @(negedge clk);
                checks += 4;
                if (n_in - in0 != 2) begin failures++; $display("FAIL stall_accepts got=%0d exp=2", n_in - in0); end
                if (qif.ofmap_rdy !== 1'b0) begin failures++; $display("FAIL stall_rdy got=%b exp=0", qif.ofmap_rdy); end
                if (qif.qout_vld !== 1'b1) begin failures++; $display("FAIL stall_vld got=%b exp=1", qif.qout_vld); end
                if (qif.qout_dat !== sb[0]) begin failures++; $display("FAIL stall_hold got=%h exp=%h", qif.qout_dat, sb[0]); end
                @(posedge clk);
                #1;
                qif.qout_rdy = 1'b1;
            end
        join
        repeat (3) push_in(32'h0000_0040, 5'd3);
        wait_drain();
        checks++;
        if (n_out - out0 != 8) begin failures++; $display("FAIL stall_outputs got=%0d exp=8", n_out - out0); end
    endtask

    task automatic test_back_to_back();
        int fd0, c0;
        logic [31:0] dat [8];
        logic [4:0]  shv [8];
        dat = '{32'hFFFF_FFDB, 32'd1000, 32'd255, 32'd7, 32'd3, 32'hFFFF_FFFB, 32'd70000, 32'd99};
        shv = '{5'd1, 5'd1, 5'd9, 5'd1, 5'd2, 5'd2, 5'd2, 5'd2};
        fd0 = n_fd;
        c0  = cyc;
        for (int i = 0; i < 8; i++) push_in(dat[i], shv[i]);
        checks++;
        if (cyc - c0 != 8) begin failures++; $display("FAIL b2b_cycles got=%0d exp=8", cyc - c0); end
        wait_drain();
        checks++;
        if (n_fd - fd0 != 2) begin failures++; $display("FAIL b2b_frame_done got=%0d exp=2", n_fd - fd0); end
    endtask

    task automatic test_random();
        bit done;
        int out0;
        done = 0;
        out0 = n_out;
        fork
            begin
                for (int i = 0; i < 16; i++) push_in($urandom, 5'($urandom_range(0, 31)));
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    qif.qout_rdy = 1'($urandom_range(0, 1));
                end
                qif.qout_rdy = 1'b1;
            end
        join
        wait_drain();
        checks++;
        if (n_out - out0 != 16) begin failures++; $display("FAIL rand_outputs got=%0d exp=16", n_out - out0); end
    endtask

    task automatic test_reset_mid();
        int fd0;
        qif.qout_rdy = 1'b1;
        push_in(32'h0000_1234, 5'd1);
        push_in(32'h0000_5678, 5'd1);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (qif.qout_vld !== 1'b0) begin failures++; $display("FAIL mid_rst_vld got=%b exp=0", qif.qout_vld); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if (qif.qout_vld !== 1'b0) begin failures++; $display("FAIL post_rst_vld got=%b exp=0", qif.qout_vld); end
        if (qif.ofmap_rdy !== 1'b1) begin failures++; $display("FAIL post_rst_rdy got=%b exp=1", qif.ofmap_rdy); end
        @(posedge clk);
        #1;
        fd0 = n_fd;
        push_in(32'h0000_0100, 5'd3);
        push_in(32'h0000_0101, 5'd0);
        push_in(32'h0000_0102, 5'd0);
        push_in(32'h0000_0103, 5'd0);
        wait_drain();
        checks += 2;
        if (n_fd - fd0 != 1) begin failures++; $display("FAIL post_rst_frame got=%0d exp=1", n_fd - fd0); end
        if (qif.sat_cnt !== 16'd0) begin failures++; $display("FAIL post_rst_sat got=%0d exp=0", qif.sat_cnt); end
    endtask

    initial begin
        rst           = 1'b1;
        qif.ofmap_vld = 1'b0;
        qif.ofmap_dat = '0;
        qif.shift     = '0;
        qif.qout_rdy  = 1'b1;
        test_reset();
        test_basic();
        test_saturate();
        test_negative();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
